// File: rtl/gf_digit_serial_mult_if.sv
// Operand/result handshake bundle for the GF(2^M) digit-serial multiplier.
// Source side drives a/b with in_valid; sink side returns c with out_valid/out_ready.
interface gf_digit_serial_mult_if #(
    parameter int M = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] c;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c
    );
endinterface

// File: rtl/gf_digit_serial_mult.sv
// GF(2^M) polynomial-basis multiplier, C = A*B mod P, one D-bit digit of B per cycle, MSB digit first.
// Latency: accept edge + M/D compute edges; out_valid rises after the last compute edge.
// Backpressure: c and out_valid hold while out_ready=0; no new accept until back in IDLE.
module gf_digit_serial_mult #(
    parameter int           M    = 16,
    parameter int           D    = 4,
    parameter logic [M-1:0] POLY = 16'h100B
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gf_digit_serial_mult_if.slave  bus
);

    localparam int NDIG = M / D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int IW   = $clog2(M);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [M-1:0]   a_r;
    logic [M-1:0]   b_r;
    logic [M-1:0]   acc;
    logic [CW-1:0]  cnt;

    logic [M-1:0]   a_pow [D];
    logic [M-1:0]   acc_sh;
    logic [M-1:0]   acc_nxt;
    logic [IW-1:0]  base;
    logic [D-1:0]   digit;

    // One step of multiplication by x, reduced modulo P(x).
    function automatic logic [M-1:0] mulx(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
    endfunction

    always_comb begin
        a_pow[0] = a_r;
        for (int j = 1; j < D; j++) begin
            a_pow[j] = mulx(a_pow[j-1]);
        end

        acc_sh = acc;
        for (int k = 0; k < D; k++) begin
            acc_sh = mulx(acc_sh);
        end

        // cnt*D never exceeds M-D, so the base always fits the index width.
        base  = IW'(cnt) * IW'(D);
        digit = b_r[base +: D];

        acc_nxt = acc_sh;
        for (int j = 0; j < D; j++) begin
            if (digit[j]) begin
                acc_nxt = acc_nxt ^ a_pow[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            acc <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r <= bus.a;
                        b_r <= bus.b;
                        acc <= '0;
                        cnt <= CW'(NDIG - 1);
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.c = acc;

endmodule
